// File: rtl/pid_profile.sv
//======================================================================
// pid_profile: angle-positioning PID with accel/cruise/decel profile.
// Revision: 1.0
//======================================================================
`default_nettype none

module pid_profile #(
    parameter int ANGLE_W       = 12,
    parameter int PWM_W         = 8,
    parameter int ACCEL_LOG2    = 6,
    parameter int DECEL_START   = 40,
    parameter int DONE_TOL      = 10,
    parameter int INT_LIMIT     = 4095,
    parameter int STALL_SAMPLES = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [ANGLE_W-1:0] target_angle,
    input  logic [ANGLE_W-1:0] current_angle,
    input  logic               sample_valid,
    input  logic               angle_update,
    input  logic               abort_angle,
    input  logic               pwm_enable,
    input  logic               enable_stall_chk,
    input  logic [7:0]         kp,
    input  logic [3:0]         ki,
    input  logic [3:0]         kd,
    output logic [PWM_W-1:0]   pwm_ratio,
    output logic               pwm_direction,
    output logic               pwm_update,
    output logic               angle_done,
    output logic               stalled,
    output logic [15:0]        debug_signals
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEL  = 3'd1,
        CRUISE = 3'd2,
        DECEL  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int IW    = $clog2(INT_LIMIT + 1);
    localparam int IS_W  = ANGLE_W + 5;
    localparam int SW    = ANGLE_W + 12;
    localparam int SCW   = $clog2(STALL_SAMPLES + 1);
    localparam int PAD_W = 16 - 4 - ACCEL_LOG2;

    localparam logic [ANGLE_W-1:0]    HALF       = ANGLE_W'(1 << (ANGLE_W - 1));
    localparam logic [ANGLE_W-1:0]    DECEL_TH   = ANGLE_W'(DECEL_START);
    localparam logic [ANGLE_W-1:0]    DONE_TH    = ANGLE_W'(DONE_TOL);
    localparam logic [IS_W-1:0]       ILIM       = IS_W'(INT_LIMIT);
    localparam logic [SCW-1:0]        STALL_LAST = SCW'(STALL_SAMPLES - 1);
    localparam logic [ACCEL_LOG2-1:0] STEP_LAST  = '1;
    localparam logic signed [SW-1:0]  PWM_MAX    = {{(SW-PWM_W){1'b0}}, {PWM_W{1'b1}}};

    state_t                state, state_n;
    logic                  sample_d, sample_tick, pid_tick;
    logic [ANGLE_W-1:0]    target_latched, target_n, target_eff, diff;
    logic [ANGLE_W-1:0]    delta, delta_prev, delta_new;
    logic                  dir_new, accept, stall_arm, stall_hit;
    logic [ACCEL_LOG2-1:0] step, step_n;
    logic [IW-1:0]         integ, integ_n, integ_next;
    logic [SCW-1:0]        stall_cnt;
    logic [PWM_W-1:0]      ratio_n, sum_sat, sum_half, ramp;
    logic                  done_n, stalled_n;

    assign sample_tick = sample_valid & ~sample_d;
    assign accept      = (state == IDLE) & angle_update & pwm_enable & ~abort_angle;

    // Shortest-path error; a move accepted this cycle already sees its new target.
    assign target_eff = accept ? target_angle : target_latched;
    assign diff       = target_eff - current_angle;
    assign dir_new    = (diff <= HALF);
    assign delta_new  = dir_new ? diff : (ANGLE_W'(0) - diff);

    logic [ANGLE_W+7:0]       p_term;
    logic [ANGLE_W+3:0]       i_add;
    logic [IS_W-1:0]          i_sum;
    logic signed [ANGLE_W:0]  d_diff;
    logic signed [SW-1:0]     d_term, sum_raw, sum_shift;
    logic [PWM_W+ACCEL_LOG2:0] ramp_prod;

    always_comb begin
        p_term     = {{ANGLE_W{1'b0}}, kp} * {8'b0, delta};
        i_add      = {{ANGLE_W{1'b0}}, ki} * {4'b0, delta};
        i_sum      = {{(IS_W-IW){1'b0}}, integ} + {1'b0, i_add};
        integ_next = (i_sum > ILIM) ? IW'(INT_LIMIT) : IW'(i_sum);
        d_diff     = $signed({1'b0, delta_prev}) - $signed({1'b0, delta});
        d_term     = $signed({{(SW-ANGLE_W-1){d_diff[ANGLE_W]}}, d_diff})
                   * $signed({{(SW-4){1'b0}}, kd});
        sum_raw    = $signed({{(SW-ANGLE_W-8){1'b0}}, p_term})
                   + $signed({{(SW-IW){1'b0}}, integ_next}) - d_term;
        sum_shift  = sum_raw >>> 4;
        if (sum_shift < 0)
            sum_sat = '0;
        else if (sum_shift > PWM_MAX)
            sum_sat = '1;
        else
            sum_sat = PWM_W'(sum_shift);
        sum_half   = sum_sat >> 1;
        ramp_prod  = {{(ACCEL_LOG2+1){1'b0}}, sum_sat}
                   * {{PWM_W{1'b0}}, ({1'b0, step} + (ACCEL_LOG2+1)'(1))};
        ramp       = PWM_W'(ramp_prod >> ACCEL_LOG2);
    end

    assign stall_arm = enable_stall_chk & ((state == ACCEL) | (state == CRUISE));
    assign stall_hit = stall_arm & pid_tick & (delta >= delta_prev) & (stall_cnt == STALL_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sample_d      <= 1'b0;
            pid_tick      <= 1'b0;
            delta         <= '0;
            delta_prev    <= '0;
            pwm_direction <= 1'b0;
            stall_cnt     <= '0;
        end else begin
            sample_d <= sample_valid;
            pid_tick <= sample_tick;
            if (sample_tick) begin
                delta         <= delta_new;
                delta_prev    <= delta;
                pwm_direction <= dir_new;
            end
            if (!stall_arm)
                stall_cnt <= '0;
            else if (pid_tick)
                stall_cnt <= (delta >= delta_prev) ? stall_cnt + SCW'(1) : '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            pwm_ratio      <= '0;
            step           <= '0;
            integ          <= '0;
            angle_done     <= 1'b0;
            stalled        <= 1'b0;
            target_latched <= '0;
        end else begin
            state          <= state_n;
            pwm_ratio      <= ratio_n;
            step           <= step_n;
            integ          <= integ_n;
            angle_done     <= done_n;
            stalled        <= stalled_n;
            target_latched <= target_n;
        end
    end

    always_comb begin
        state_n   = state;
        ratio_n   = pwm_ratio;
        step_n    = step;
        integ_n   = integ;
        done_n    = angle_done;
        stalled_n = stalled;
        target_n  = target_latched;
        case (state)
            IDLE: begin
                ratio_n = '0;
                step_n  = '0;
                integ_n = '0;
                if (accept) begin
                    target_n  = target_angle;
                    done_n    = 1'b0;
                    stalled_n = 1'b0;
                    state_n   = ACCEL;
                end
            end
            ACCEL, CRUISE, DECEL: begin
                if (abort_angle || !pwm_enable) begin
                    state_n = IDLE;
                    ratio_n = '0;
                end else if (stall_hit) begin
                    stalled_n = 1'b1;
                    state_n   = IDLE;
                    ratio_n   = '0;
                end else if (pid_tick) begin
                    integ_n = integ_next;
                    if (state == DECEL) begin
                        if (delta <= DONE_TH) begin
                            state_n = DONE;
                            ratio_n = '0;
                            done_n  = 1'b1;
                        end else begin
                            ratio_n = sum_half;
                        end
                    end else if (delta < DECEL_TH) begin
                        state_n = DECEL;
                        ratio_n = sum_half;
                    end else if (state == ACCEL) begin
                        ratio_n = ramp;
                        step_n  = step + ACCEL_LOG2'(1);
                        if (step == STEP_LAST)
                            state_n = CRUISE;
                    end else begin
                        ratio_n = sum_sat;
                    end
                end
            end
            DONE: begin
                ratio_n = '0;
                state_n = IDLE;
            end
            default: begin
                ratio_n = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign pwm_update    = (state == ACCEL) | (state == CRUISE) | (state == DECEL);
    assign debug_signals = {state, pwm_direction, step, {PAD_W{1'b0}}};

endmodule

`default_nettype wire

// File: tb/tb_pid_profile.sv
//======================================================================
// tb_pid_profile: directed self-checking bench for pid_profile.
// Revision: 1.0
//======================================================================
`default_nettype none

module tb_pid_profile;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [11:0] target_angle, current_angle;
    logic        sample_valid, angle_update, abort_angle, pwm_enable, enable_stall_chk;
    logic [7:0]  kp;
    logic [3:0]  ki, kd;
    logic [7:0]  pwm_ratio;
    logic        pwm_direction, pwm_update, angle_done, stalled;
    logic [15:0] debug_signals;

    int tests = 0;
    int fails = 0;

    pid_profile dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .target_angle     (target_angle),
        .current_angle    (current_angle),
        .sample_valid     (sample_valid),
        .angle_update     (angle_update),
        .abort_angle      (abort_angle),
        .pwm_enable       (pwm_enable),
        .enable_stall_chk (enable_stall_chk),
        .kp               (kp),
        .ki               (ki),
        .kd               (kd),
        .pwm_ratio        (pwm_ratio),
        .pwm_direction    (pwm_direction),
        .pwm_update       (pwm_update),
        .angle_done       (angle_done),
        .stalled          (stalled),
        .debug_signals    (debug_signals)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One encoder sample; returns on the negedge after the PID result lands.
    task automatic sample(input logic [11:0] cur);
        @(negedge clock);
        current_angle = cur;
        sample_valid  = 1'b1;
        @(negedge clock);
        sample_valid  = 1'b0;
        @(negedge clock);
    endtask

    task automatic start_move(input logic [11:0] tgt);
        @(negedge clock);
        target_angle = tgt;
        angle_update = 1'b1;
        pwm_enable   = 1'b1;
        @(negedge clock);
        angle_update = 1'b0;
    endtask

    task automatic stop_move();
        @(negedge clock);
        pwm_enable = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0; sample_valid = 1'b0; angle_update = 1'b0; abort_angle = 1'b0;
        pwm_enable = 1'b0; enable_stall_chk = 1'b0;
        kp = 8'd16; ki = 4'd0; kd = 4'd0;
        target_angle = '0; current_angle = '0;
        repeat (3) @(negedge clock);
        chk("rst_ratio",   32'(pwm_ratio),     0);
        chk("rst_update",  32'(pwm_update),    0);
        chk("rst_dir",     32'(pwm_direction), 0);
        chk("rst_done",    32'(angle_done),    0);
        chk("rst_stalled", 32'(stalled),       0);
        chk("rst_debug",   32'(debug_signals), 0);
        @(negedge clock) reset_n = 1'b1;

        // Ramp with saturated sum (1000 -> 255)
        start_move(12'd1000);
        chk("accel_state",  32'(debug_signals[15:13]), 1);
        chk("accel_update", 32'(pwm_update), 1);
        sample(12'd0);
        chk("ramp1",      32'(pwm_ratio), 3);
        chk("ramp1_dir",  32'(pwm_direction), 1);
        chk("ramp1_step", 32'(debug_signals[11:6]), 1);
        sample(12'd0);
        chk("ramp2", 32'(pwm_ratio), 7);
        for (int k = 3; k <= 63; k++) begin
            sample(12'd0);
            chk("ramp_k", 32'(pwm_ratio), 32'((255 * k) >> 6));
        end
        sample(12'd0);
        chk("ramp64",       32'(pwm_ratio), 255);
        chk("cruise_state", 32'(debug_signals[15:13]), 2);
        sample(12'd0);
        chk("cruise_ratio", 32'(pwm_ratio), 255);

        // Approach: decel at delta 39, done at delta 10
        sample(12'd961);
        chk("decel_state", 32'(debug_signals[15:13]), 3);
        chk("decel_ratio", 32'(pwm_ratio), 19);
        sample(12'd970);
        chk("decel_ratio2", 32'(pwm_ratio), 15);
        sample(12'd990);
        chk("done_state",  32'(debug_signals[15:13]), 4);
        chk("done_ratio",  32'(pwm_ratio), 0);
        chk("done_flag",   32'(angle_done), 1);
        chk("done_update", 32'(pwm_update), 0);
        @(negedge clock);
        chk("post_done_idle", 32'(debug_signals[15:13]), 0);
        chk("post_done_flag", 32'(angle_done), 1);

        // Wrap-around both directions, short moves
        start_move(12'd10);
        chk("wrap_done_clr", 32'(angle_done), 0);
        sample(12'd4090);
        chk("wrap_fwd_dir",   32'(pwm_direction), 1);
        chk("wrap_fwd_state", 32'(debug_signals[15:13]), 3);
        chk("wrap_fwd_ratio", 32'(pwm_ratio), 8);
        stop_move();
        chk("disable_idle",  32'(debug_signals[15:13]), 0);
        chk("disable_ratio", 32'(pwm_ratio), 0);
        chk("disable_done",  32'(angle_done), 0);
        start_move(12'd4090);
        sample(12'd10);
        chk("wrap_rev_dir",   32'(pwm_direction), 0);
        chk("wrap_rev_state", 32'(debug_signals[15:13]), 3);
        chk("wrap_rev_ratio", 32'(pwm_ratio), 8);
        sample(12'd4085);
        chk("small_done_state", 32'(debug_signals[15:13]), 4);
        chk("small_done_flag",  32'(angle_done), 1);

        // Abort in CRUISE together with a new angle_update
        start_move(12'd1000);
        repeat (64) sample(12'd0);
        chk("abort_pre_cruise", 32'(debug_signals[15:13]), 2);
        @(negedge clock);
        abort_angle = 1'b1; angle_update = 1'b1; target_angle = 12'd3000;
        @(negedge clock);
        chk("abort_idle",   32'(debug_signals[15:13]), 0);
        chk("abort_ratio",  32'(pwm_ratio), 0);
        chk("abort_done",   32'(angle_done), 0);
        chk("abort_update", 32'(pwm_update), 0);
        abort_angle = 1'b0; angle_update = 1'b0;
        sample(12'd0);
        chk("abort_target_kept", 32'(pwm_direction), 1);
        chk("idle_ratio",        32'(pwm_ratio), 0);

        // Stall detection in CRUISE
        start_move(12'd1000);
        repeat (64) sample(12'd0);
        enable_stall_chk = 1'b1;
        repeat (15) sample(12'd0);
        chk("stall15_flag",  32'(stalled), 0);
        chk("stall15_state", 32'(debug_signals[15:13]), 2);
        sample(12'd0);
        chk("stall16_flag",  32'(stalled), 1);
        chk("stall16_state", 32'(debug_signals[15:13]), 0);
        chk("stall16_ratio", 32'(pwm_ratio), 0);
        start_move(12'd1000);
        enable_stall_chk = 1'b0;
        chk("stall_cleared", 32'(stalled), 0);
        chk("stall_restart", 32'(debug_signals[15:13]), 1);
        stop_move();

        // Integral clamp: ki=15, delta 1000
        kp = 8'd0; ki = 4'd15;
        start_move(12'd1000);
        sample(12'd0);
        chk("int_ramp1", 32'(pwm_ratio), 3);
        repeat (63) sample(12'd0);
        chk("int_cruise_state", 32'(debug_signals[15:13]), 2);
        for (int k = 0; k < 3; k++) begin
            sample(12'd0);
            chk("int_clamp_ratio", 32'(pwm_ratio), 255);
        end
        stop_move();

        // Signed derivative term in CRUISE (kp=0.25, kd=15/16)
        kp = 8'd4; ki = 4'd0; kd = 4'd15;
        start_move(12'd1000);
        repeat (64) sample(12'd0);
        sample(12'd0);
        chk("d_zero",  32'(pwm_ratio), 250);
        sample(12'd20);
        chk("d_pos",   32'(pwm_ratio), 226);
        sample(12'd0);
        chk("d_neg_sat", 32'(pwm_ratio), 255);
        sample(12'd400);
        chk("d_neg_sum_zero", 32'(pwm_ratio), 0);
        chk("d_state",        32'(debug_signals[15:13]), 2);

        // Asynchronous reset mid-move
        #3 reset_n = 1'b0;
        #1;
        chk("mid_rst_ratio",  32'(pwm_ratio), 0);
        chk("mid_rst_update", 32'(pwm_update), 0);
        chk("mid_rst_dir",    32'(pwm_direction), 0);
        chk("mid_rst_debug",  32'(debug_signals), 0);
        @(negedge clock) reset_n = 1'b1;
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pid_profile.md
PID_PROFILE -- requirements
Module: pid_profile

Interface
REQ-001 Parameter ANGLE_W, 12, encoder/target angle width (counts per rotation = 2^ANGLE_W).
REQ-002 Parameter PWM_W, 8, pwm_ratio width.
REQ-003 Parameter ACCEL_LOG2, 6, log2 of the accel ramp length in samples (ramp = 2^ACCEL_LOG2 samples).
REQ-004 Parameter DECEL_START, 40, delta below which DECEL is entered.
REQ-005 Parameter DONE_TOL, 10, delta at or below which the move completes.
REQ-006 Parameter INT_LIMIT, 4095, integral accumulator clamp magnitude.
REQ-007 Parameter STALL_SAMPLES, 16, consecutive non-improving samples that declare a stall.
REQ-008 clock  in  1  main clock; reset_n  in  1  reset, asynchronous, active-low.
REQ-009 target_angle  in  ANGLE_W  requested angle, latched on angle_update.
REQ-010 current_angle  in  ANGLE_W  encoder angle, valid when sample_valid rises.
REQ-011 sample_valid  in  1  encoder read done (level; rising edge = new sample).
REQ-012 angle_update  in  1  start move; abort_angle  in  1  cancel move; pwm_enable  in  1  motor enable.
REQ-013 enable_stall_chk  in  1  enables stall detection.
REQ-014 kp  in  8  fixed 4.4; ki  in  4  fixed 0.4; kd  in  4  fixed 0.4.
REQ-015 pwm_ratio  out  PWM_W  duty; pwm_direction  out  1  1 = forward (shortest path); pwm_update  out  1  duty valid/active.
REQ-016 angle_done  out  1  move complete (level); stalled  out  1  sticky stall error.
REQ-017 debug_signals  out  16  {state[2:0], pwm_direction, step[ACCEL_LOG2-1:0], zero-padded}.

Function
REQ-018 Sample edge: sample_valid registered; one-cycle sample_tick = rising edge; all PID/profile updates occur only on sample_tick.
REQ-019 Delta: diff = (target_latched - current_angle) mod 2^ANGLE_W; diff <= 2^(ANGLE_W-1) -> dir=1, delta=diff; else dir=0, delta=2^ANGLE_W-diff; delta/dir registered on sample_tick.
REQ-020 PID terms (computed from registered delta, one cycle after sample_tick): P = kp*delta; I += ki*delta, clamped to INT_LIMIT, cleared in IDLE; D = kd*(delta_prev - delta), signed.
REQ-021 sum = (P + I - D) >> 4, arithmetic; negative -> 0; > 2^PWM_W-1 -> 2^PWM_W-1 (saturation, no wrap).
REQ-022 States IDLE, ACCEL, CRUISE, DECEL, DONE; encoding 3 bits.
REQ-023 IDLE: pwm_ratio=0, pwm_update=0, step=0; angle_update & pwm_enable & ~abort_angle -> latch target, clear angle_done, clear stalled, -> ACCEL.
REQ-024 ACCEL: per sample pwm_ratio = (sum*(step+1)) >> ACCEL_LOG2, step++; step reaches 2^ACCEL_LOG2-1 -> CRUISE; delta < DECEL_START -> DECEL (takes priority over ramp).
REQ-025 CRUISE: pwm_ratio = sum; delta < DECEL_START -> DECEL.
REQ-026 DECEL: pwm_ratio = sum >> 1; delta <= DONE_TOL -> DONE.
REQ-027 DONE: pwm_ratio=0, angle_done=1 held until next angle_update accepted; state -> IDLE next cycle.
REQ-028 pwm_update = 1 in ACCEL/CRUISE/DECEL, 0 otherwise; pwm_direction = registered dir.
REQ-029 abort_angle or ~pwm_enable in any active state -> IDLE next cycle, pwm_ratio=0, angle_done unchanged (0).
REQ-030 Priority: abort_angle > ~pwm_enable > stall > state transitions; angle_update outside IDLE ignored.
REQ-031 Stall: enable_stall_chk in ACCEL/CRUISE; counter increments on each sample with delta >= delta_prev, clears on delta < delta_prev; reaching STALL_SAMPLES -> stalled=1, -> IDLE.
REQ-032 Wrap-around: target/current across 0 handled solely by REQ-019 (e.g. target 10, current 4090 -> delta 16, dir 1).
REQ-033 Move may start with delta <= DONE_TOL: ACCEL -> DECEL -> DONE on consecutive samples.

Reset
REQ-034 Async reset: state=IDLE, pwm_ratio=0, pwm_update=0, pwm_direction=0, angle_done=0, stalled=0, I=0, delta/delta_prev=0, step=0, stall counter=0; mid-move reset forces these within the reset assertion.

Verification
REQ-035 kp=16 (1.0), ki=kd=0, target 1000, current 0 -> dir=1, ratio ramps 3,7,... saturating 255 (sum=1000 clamps to 255), CRUISE after 64 samples.
REQ-036 target 10, current 4090 -> delta 16, dir=1; target 4090, current 10 -> delta 16, dir=0.
REQ-037 current stepped to within 39 of target -> DECEL, ratio halved; within 10 -> angle_done=1, ratio 0, IDLE.
REQ-038 abort_angle asserted in CRUISE together with angle_update -> IDLE next cycle, ratio 0, angle_done 0, new target not latched.
REQ-039 enable_stall_chk=1, current held constant for 16 samples in CRUISE -> stalled=1, IDLE; next angle_update clears stalled.
REQ-040 ki=15, large constant delta -> integral clamps at 4095, sum saturates at 255, no wrap to low duty.
